// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : elevator_scheduler
// Brief    : Single-car SCAN scheduler with 4-phase stepper drive and door timer.
// Revision : 1.0  initial release
// ============================================================================
module elevator_scheduler #(
  parameter int NUM_FLOORS      = 9,
  parameter int STEP_DIV        = 240000,
  parameter int STEPS_PER_FLOOR = 4,
  parameter int DOOR_CYCLES     = 24000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] push_btns,
  output logic [3:0]            motor_out,
  output logic [3:0]            cur_floor,
  output logic                  moving,
  output logic                  dir,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int c_STEP_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int c_FSTEP_W = (STEPS_PER_FLOOR > 1) ? $clog2(STEPS_PER_FLOOR) : 1;
  localparam int c_DOOR_W  = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [c_STEP_W-1:0]   c_STEP_LAST  = c_STEP_W'(STEP_DIV - 1);
  localparam logic [c_FSTEP_W-1:0]  c_FSTEP_LAST = c_FSTEP_W'(STEPS_PER_FLOOR - 1);
  localparam logic [c_DOOR_W-1:0]   c_DOOR_LAST  = c_DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [3:0]            c_TOP        = 4'(NUM_FLOORS - 1);
  localparam logic [NUM_FLOORS-1:0] c_ONE        = NUM_FLOORS'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_DOOR = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_FLOORS-1:0] r_btn_hist, r_pending, w_pending_nxt;
  logic [NUM_FLOORS-1:0] w_req, w_pend_set, w_here_mask, w_arr_mask;
  logic [3:0]            r_cur_floor, w_floor_nxt, w_arr_floor;
  logic                  r_dir, w_dir_nxt;
  logic [1:0]            r_phase, w_phase_nxt;
  logic [c_STEP_W-1:0]   r_step_cnt, w_step_nxt;
  logic [c_FSTEP_W-1:0]  r_fstep_cnt, w_fstep_nxt;
  logic [c_DOOR_W-1:0]   r_door_cnt, w_door_nxt;
  logic                  w_above, w_below, w_arr_above, w_arr_below, w_here_req;

  assign w_req       = push_btns & ~r_btn_hist;
  assign w_here_mask = c_ONE << r_cur_floor;
  assign w_here_req  = |(w_req & w_here_mask);

  // A call for the car's own floor is served by the door, never queued, unless travelling.
  assign w_pend_set = (r_state == ST_MOVE) ? (r_pending | w_req)
                                           : (r_pending | (w_req & ~w_here_mask));

  always_comb begin
    w_arr_floor = r_cur_floor;
    if (r_dir && (r_cur_floor != c_TOP))
      w_arr_floor = r_cur_floor + 4'd1;
    else if (!r_dir && (r_cur_floor != 4'd0))
      w_arr_floor = r_cur_floor - 4'd1;
  end

  assign w_arr_mask = c_ONE << w_arr_floor;

  always_comb begin
    w_above     = 1'b0;
    w_below     = 1'b0;
    w_arr_above = 1'b0;
    w_arr_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (4'(i) > r_cur_floor) w_above     = w_above     | r_pending[i];
      if (4'(i) < r_cur_floor) w_below     = w_below     | r_pending[i];
      if (4'(i) > w_arr_floor) w_arr_above = w_arr_above | w_pend_set[i];
      if (4'(i) < w_arr_floor) w_arr_below = w_arr_below | w_pend_set[i];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_floor_nxt   = r_cur_floor;
    w_dir_nxt     = r_dir;
    w_phase_nxt   = r_phase;
    w_step_nxt    = r_step_cnt;
    w_fstep_nxt   = r_fstep_cnt;
    w_door_nxt    = r_door_cnt;
    w_pending_nxt = w_pend_set;
    case (r_state)
      ST_IDLE: begin
        if (w_here_req) begin
          w_state_nxt = ST_DOOR;
          w_door_nxt  = '0;
        end else if (|r_pending) begin
          if (r_cur_floor == c_TOP)
            w_dir_nxt = 1'b0;
          else if (r_cur_floor == 4'd0)
            w_dir_nxt = 1'b1;
          else if (r_dir ? !w_above : !w_below)
            w_dir_nxt = ~r_dir;
          w_state_nxt = ST_MOVE;
          w_step_nxt  = '0;
          w_fstep_nxt = '0;
        end
      end
      ST_MOVE: begin
        if (r_step_cnt == c_STEP_LAST) begin
          w_step_nxt  = '0;
          w_phase_nxt = r_dir ? (r_phase + 2'd1) : (r_phase - 2'd1);
          if (r_fstep_cnt == c_FSTEP_LAST) begin
            w_fstep_nxt = '0;
            w_floor_nxt = w_arr_floor;
            // Calls landing on the arrival edge merge into this stop.
            if (|(w_pend_set & w_arr_mask)) begin
              w_pending_nxt = w_pend_set & ~w_arr_mask;
              w_state_nxt   = ST_DOOR;
              w_door_nxt    = '0;
            end else if (!(r_dir ? w_arr_above : w_arr_below)) begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_fstep_nxt = r_fstep_cnt + 1'b1;
          end
        end else begin
          w_step_nxt = r_step_cnt + 1'b1;
        end
      end
      ST_DOOR: begin
        if (w_here_req) begin
          w_door_nxt = '0;
        end else if (r_door_cnt == c_DOOR_LAST) begin
          w_state_nxt = ST_IDLE;
          w_door_nxt  = '0;
        end else begin
          w_door_nxt = r_door_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_btn_hist  <= '0;
      r_pending   <= '0;
      r_cur_floor <= 4'd0;
      r_dir       <= 1'b1;
      r_phase     <= 2'd0;
      r_step_cnt  <= '0;
      r_fstep_cnt <= '0;
      r_door_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_btn_hist  <= push_btns;
      r_pending   <= w_pending_nxt;
      r_cur_floor <= w_floor_nxt;
      r_dir       <= w_dir_nxt;
      r_phase     <= w_phase_nxt;
      r_step_cnt  <= w_step_nxt;
      r_fstep_cnt <= w_fstep_nxt;
      r_door_cnt  <= w_door_nxt;
    end
  end

  // Coils de-energise whenever the car is not travelling, including during reset.
  always_comb begin
    motor_out = 4'b0000;
    if (r_state == ST_MOVE) begin
      case (r_phase)
        2'd0:    motor_out = 4'b1001;
        2'd1:    motor_out = 4'b1010;
        2'd2:    motor_out = 4'b0110;
        default: motor_out = 4'b0101;
      endcase
    end
  end

  assign cur_floor = r_cur_floor;
  assign moving    = (r_state == ST_MOVE);
  assign door_open = (r_state == ST_DOOR);
  assign dir       = r_dir;
  assign pending   = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_elevator_scheduler
// Brief    : Cycle-timeline scoreboard bench for elevator_scheduler.
// Revision : 1.0  initial release
// ============================================================================
module tb_elevator_scheduler;

  localparam int NF  = 4;
  localparam int SD  = 4;
  localparam int SPF = 2;
  localparam int DC  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NF-1:0] push_btns;
  logic [3:0]    motor_out;
  logic [3:0]    cur_floor;
  logic          moving;
  logic          dir;
  logic          door_open;
  logic [NF-1:0] pending;

  elevator_scheduler #(
    .NUM_FLOORS(NF), .STEP_DIV(SD), .STEPS_PER_FLOOR(SPF), .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .push_btns(push_btns), .motor_out(motor_out),
    .cur_floor(cur_floor), .moving(moving), .dir(dir), .door_open(door_open),
    .pending(pending)
  );

  always #5 clk = ~clk;

  // Entry: expected {motor, floor, moving, dir, door, pending} at a negedge,
  // then the buttons to drive for the following rising edge.
  typedef struct {
    logic [3:0]  btns;
    logic [14:0] exp;
  } ent_t;

  ent_t       sb_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] pat [0:3] = '{4'b1001, 4'b1010, 4'b0110, 4'b0101};
  int         m_floor;
  int         m_phase;
  logic       m_dir;
  logic [3:0] m_pend;

  task automatic push(input logic [3:0] btns, input logic [3:0] motor,
                      input logic mv, input logic dr);
    ent_t e;
    e.btns = btns;
    e.exp  = {motor, 4'(m_floor), mv, m_dir, dr, m_pend};
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [3:0] btns);
    repeat (n) push(btns, 4'b0000, 1'b0, 1'b0);
  endtask

  task automatic door(input int n, input logic [3:0] btns);
    repeat (n) push(btns, 4'b0000, 1'b0, 1'b1);
  endtask

  // Travel nfl floors; optionally press pbtns at travel cycle pidx.
  task automatic travel(input int nfl, input logic up, input logic [3:0] hold,
                        input int pidx, input logic [3:0] pbtns);
    int c = 0;
    m_dir = up;
    for (int f = 0; f < nfl; f++) begin
      for (int s = 0; s < SPF; s++) begin
        for (int k = 0; k < SD; k++) begin
          push((c == pidx) ? pbtns : hold, pat[m_phase], 1'b1, 1'b0);
          if (c == pidx) m_pend = m_pend | pbtns;
          c++;
        end
        m_phase = up ? (m_phase + 1) % 4 : (m_phase + 3) % 4;
      end
      m_floor = up ? m_floor + 1 : m_floor - 1;
    end
    m_pend[m_floor] = 1'b0;
  endtask

  task automatic drive_cycle(input logic [3:0] btns, output logic [14:0] obs);
    @(negedge clk);
    obs = {motor_out, cur_floor, moving, dir, door_open, pending};
    push_btns = btns;
  endtask

  task automatic test_reset;
    logic [14:0] obs;
    repeat (2) @(negedge clk);
    obs = {motor_out, cur_floor, moving, dir, door_open, pending};
    n_checks++;
    if (obs !== 15'b0000_0000_0_1_0_0000) begin
      n_errors++;
      $display("FAIL reset_values got=%b exp=%b", obs, 15'b0000_0000_0_1_0_0000);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_call;
    ent_t e; logic [14:0] obs; int idx = 0;
    idle(1, 4'b0100);
    m_pend = 4'b0100;
    idle(1, 4'b0000);
    travel(2, 1'b1, 4'b0000, -1, 4'b0000);
    door(DC, 4'b0000);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      drive_cycle(e.btns, obs);
      idx++; n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL single_call cyc%0d got=%b exp=%b", idx, obs, e.exp);
      end
    end
  endtask

  task automatic test_reset_mid_move;
    ent_t e; logic [14:0] obs; int idx = 0;
    idle(1, 4'b1000);
    m_pend = 4'b1000;
    idle(1, 4'b0000);
    m_dir = 1'b1;
    repeat (SD) push(4'b0000, pat[m_phase], 1'b1, 1'b0);
    m_phase = (m_phase + 1) % 4;
    repeat (2) push(4'b0000, pat[m_phase], 1'b1, 1'b0);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      drive_cycle(e.btns, obs);
      idx++; n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL reset_pre cyc%0d got=%b exp=%b", idx, obs, e.exp);
      end
    end
    #2 rst = 1'b1;
    #1 obs = {motor_out, cur_floor, moving, dir, door_open, pending};
    n_checks++;
    if (obs !== 15'b0000_0000_0_1_0_0000) begin
      n_errors++;
      $display("FAIL reset_async got=%b exp=%b", obs, 15'b0000_0000_0_1_0_0000);
    end
    @(negedge clk);
    rst = 1'b0;
    m_floor = 0; m_phase = 0; m_dir = 1'b1; m_pend = 4'b0000;
  endtask

  task automatic test_scan_order;
    ent_t e; logic [14:0] obs; int idx = 0;
    idle(1, 4'b0100);
    m_pend = 4'b0100;
    idle(1, 4'b0000);
    travel(2, 1'b1, 4'b0000, 1, 4'b0001);
    door(DC, 4'b0000);
    idle(1, 4'b0000);
    travel(2, 1'b0, 4'b0000, -1, 4'b0000);
    door(DC, 4'b0000);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      drive_cycle(e.btns, obs);
      idx++; n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL scan_order cyc%0d got=%b exp=%b", idx, obs, e.exp);
      end
    end
  endtask

  task automatic test_door_restart;
    ent_t e; logic [14:0] obs; int idx = 0;
    idle(1, 4'b0001);
    door(2, 4'b0000);
    door(1, 4'b0001);
    door(DC, 4'b0000);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      drive_cycle(e.btns, obs);
      idx++; n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL door_restart cyc%0d got=%b exp=%b", idx, obs, e.exp);
      end
    end
  endtask

  task automatic test_simultaneous_top;
    ent_t e; logic [14:0] obs; int idx = 0;
    idle(1, 4'b1010);
    m_pend = 4'b1010;
    idle(1, 4'b0000);
    travel(1, 1'b1, 4'b0000, -1, 4'b0000);
    door(DC, 4'b0000);
    idle(1, 4'b0000);
    travel(2, 1'b1, 4'b0000, -1, 4'b0000);
    door(DC, 4'b0000);
    idle(1, 4'b0001);
    m_pend = 4'b0001;
    idle(1, 4'b0000);
    travel(3, 1'b0, 4'b0000, -1, 4'b0000);
    door(DC, 4'b0000);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      drive_cycle(e.btns, obs);
      idx++; n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL simultaneous_top cyc%0d got=%b exp=%b", idx, obs, e.exp);
      end
    end
  endtask

  task automatic test_held_button;
    ent_t e; logic [14:0] obs; int idx = 0;
    idle(1, 4'b1000);
    m_pend = 4'b1000;
    idle(1, 4'b1000);
    travel(3, 1'b1, 4'b1000, -1, 4'b0000);
    door(DC, 4'b1000);
    idle(50 - (2 + 3 * SPF * SD + DC), 4'b1000);
    idle(4, 4'b0000);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      drive_cycle(e.btns, obs);
      idx++; n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL held_button cyc%0d got=%b exp=%b", idx, obs, e.exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    ent_t e; logic [14:0] obs; int idx = 0;
    idle(1, 4'b0010);
    m_pend = 4'b0010;
    idle(1, 4'b0000);
    travel(2, 1'b0, 4'b0000, 2 * SPF * SD - 1, 4'b0010);
    door(DC, 4'b0000);
    idle(2, 4'b0000);
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      drive_cycle(e.btns, obs);
      idx++; n_checks++;
      if (obs !== e.exp) begin
        n_errors++;
        $display("FAIL arrival_merge cyc%0d got=%b exp=%b", idx, obs, e.exp);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    push_btns = '0;
    m_floor   = 0;
    m_phase   = 0;
    m_dir     = 1'b1;
    m_pend    = 4'b0000;
    test_reset();
    test_single_call();
    test_reset_mid_move();
    test_scan_order();
    test_door_restart();
    test_simultaneous_top();
    test_held_button();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/elevator_scheduler.md
# elevator_scheduler

Single-car elevator scheduler. Latches floor-call buttons into a pending-request register and picks travel direction with a SCAN (collective) policy. Drives the 4-phase stepper coil pattern floor by floor and holds the door open at each serviced floor. Sits between the push-button inputs and the stepper-motor driver pins, and replaces free-running motor stepping with request-driven sequencing.

## Interface
- NUM_FLOORS, 9: number of floors and call buttons (2..16); floor 0 is the lowest.
- STEP_DIV, 240000: clk cycles per motor phase step.
- STEPS_PER_FLOOR, 4: phase steps needed to travel one floor (at least 1).
- DOOR_CYCLES, 24000000: clk cycles the door stays open.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- push_btns  in  NUM_FLOORS  call buttons, already synchronous levels; bit i calls floor i.
- motor_out  out  4  stepper coil pattern.
- cur_floor  out  4  current floor index.
- moving  out  1  high while in MOVE.
- dir  out  1  1 = up, 0 = down; the last or current travel direction.
- door_open  out  1  high while in DOOR.
- pending  out  NUM_FLOORS  outstanding call flags.

## Operation
- Reset values: state IDLE, motor_out 4'b0000, cur_floor 0, moving 0, dir 1, door_open 0, pending all 0, phase index 0, all counters 0, button history 0.
- Edge detect: a request occurs when push_btns[i] is 1 and its registered history is 0. Holding a button produces one request only.
- Request handling:
  - At floor i while in IDLE or DOOR: no pending bit is set. IDLE goes to DOOR. In DOOR the door timer restarts at 0.
  - Otherwise: pending[i] is set. Setting an already-set bit is harmless.
- Phase patterns, indexed 0..3: 1001, 1010, 0110, 0101.
  - Each step up: index + 1 mod 4. Each step down: index − 1 mod 4.
  - The index is kept across moves.
  - motor_out shows the pattern for the current index in MOVE and 0000 in every other state.
- States and transitions:
  - IDLE: if nothing is pending, stay.
    - If pending floors exist in direction dir, keep dir.
    - Otherwise reverse dir.
    - Then go to MOVE with both counters at 0.
  - MOVE: the step counter runs 0..STEP_DIV−1. When it wraps, the phase index advances and the floor-step counter increments.
    - When the floor-step counter reaches STEPS_PER_FLOOR, cur_floor changes by ±1 and the counter clears.
    - On that same edge, if the new floor is pending: clear its bit and go to DOOR.
    - Else if any floor is pending further in dir: stay in MOVE.
    - Else: go to IDLE (defensive case).
  - DOOR: the door counter counts up to DOOR_CYCLES−1, then the state goes to IDLE.
- Boundaries:
  - cur_floor never goes below 0 or above NUM_FLOORS−1.
  - dir is forced to 0 at the top floor and to 1 at floor 0 whenever IDLE chooses a direction.
- Simultaneous events:
  - Any number of buttons may assert in the same cycle; each is handled independently.
  - A request for the floor being arrived at on the arrival edge is merged into that floor's service. The bit ends up clear and the door opens.
- Reset mid-operation: all state returns to reset values immediately. motor_out goes to 0000 asynchronously and pending requests are lost.

## Timing
- Request latency: a button rising at the sampling edge k shows in pending after edge k.
- IDLE decision: MOVE is entered on the edge after pending becomes non-zero, so moving = 1 one cycle after pending is visible.
- First phase change: STEP_DIV cycles after MOVE is entered.
- Floor travel: exactly STEP_DIV × STEPS_PER_FLOOR cycles per floor, with no gap between consecutive floors.
- Arrival: cur_floor update, pending clear, door_open = 1 and motor_out = 0000 all take effect on the same edge.
- Door: door_open is high for exactly DOOR_CYCLES cycles, unless restarted by a request for the current floor. IDLE follows on the next edge.

## Test plan
Bench parameters for all scenarios: NUM_FLOORS=4, STEP_DIV=4, STEPS_PER_FLOOR=2, DOOR_CYCLES=5.
- Reset check: assert rst mid-MOVE → all outputs return to reset values within the same cycle, asynchronously; motor_out = 0000 and cur_floor = 0.
- Single call: pulse push_btns[2] from IDLE at floor 0.
  - pending = 0100 next cycle, then moving = 1.
  - motor_out steps through 1010, 0110, 0101, 1001 at 4-cycle intervals.
  - cur_floor = 1 after 8 cycles and 2 after 16 cycles.
  - pending = 0000, door_open = 1 for 5 cycles, then IDLE.
- SCAN order: at floor 1, going up, with pending 0101 →
  - services floor 2 first, with dir = 1;
  - then, after the door closes, sets dir = 0 and services floor 0;
  - reverse phase order on the way down: 0110, 1010, 1001, 0101.
- Door restart: press push_btns[cur_floor] during DOOR after 3 cycles → door_open stays high for 5 more cycles; pending unchanged.
- Held button: hold push_btns[3] high for 50 cycles → exactly one service of floor 3; no repeat door cycle while the button remains held.
- Simultaneous and top boundary: press push_btns[3] and push_btns[1] in the same cycle at floor 0 →
  - stops at 1, then at 3;
  - the next IDLE selection at floor 3 with a new call to 0 gives dir = 0;
  - cur_floor never exceeds 3.
